uart_tx_cfg: RTL and testbench

//  Parametrised, runtime-configurable UART transmitter: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.

---
 rtl/uart_tx_cfg_pkg.sv | 55 +++++
 rtl/uart_tx_cfg_if.sv | 21 ++
 rtl/uart_tx_cfg_hold.sv | 41 ++++
 rtl/uart_tx_cfg.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_cfg_pkg.sv
// Shared UART definitions: FSM states, parity modes, frame-config record and helpers.
package uart_tx_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam logic [1:0] ParNone = 2'b00;
    localparam logic [1:0] ParEven = 2'b01;
    localparam logic [1:0] ParOdd  = 2'b10;
    localparam logic [1:0] ParRsvd = 2'b11;

    // Widest frame the config field can select; parity is computed over this many bits.
    localparam int unsigned MaxDbit = 8;

    typedef struct packed {
        logic [1:0] dbits;
        logic [1:0] par;
        logic       stop2;
    } tx_cfg_t;

    // 00..11 -> 5..8 data bits
    function automatic logic [3:0] dbits_decode(input logic [1:0] cfg_dbits);
        return 4'd5 + {2'b00, cfg_dbits};
    endfunction

    // Reserved mode behaves as no parity
    function automatic logic parity_en(input logic [1:0] par);
        return (par == ParEven) || (par == ParOdd);
    endfunction

    // Parity over the active data bits only; bits above the configured width are ignored
    function automatic logic parity_calc(input logic [MaxDbit-1:0] data,
                                         input logic [1:0]         cfg_dbits,
                                         input logic [1:0]         par);
        logic       p;
        logic [3:0] n;
        p = 1'b0;
        n = dbits_decode(cfg_dbits);
        for (int i = 0; i < MaxDbit; i++) begin
            if (4'(i) < n) begin
                p = p ^ data[i];
            end
        end
        if (par == ParOdd) begin
            p = ~p;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side valid/ready word interface of the UART transmitter (payload plus per-frame config).
interface uart_tx_cfg_if #(
    parameter int unsigned DBIT = 8
) ();
    logic [DBIT-1:0] tx_data;
    logic [1:0]      cfg_dbits;
    logic [1:0]      cfg_par;
    logic            cfg_stop2;
    logic            tx_valid;
    logic            tx_ready;

    modport master (
        output tx_data, cfg_dbits, cfg_par, cfg_stop2, tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data, cfg_dbits, cfg_par, cfg_stop2, tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_cfg_hold.sv
// One-entry holding register for a word accepted while a frame is still on the line.
module uart_tx_cfg_hold
    import uart_tx_cfg_pkg::*;
#(
    parameter int unsigned DBIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic [DBIT-1:0] i_data,
    input  tx_cfg_t         i_cfg,
    input  logic            i_drain,
    output logic            o_valid,
    output logic [DBIT-1:0] o_data,
    output tx_cfg_t         o_cfg
);

    logic            r_valid;
    logic [DBIT-1:0] r_data;
    tx_cfg_t         r_cfg;

    // Fill on load, empty on drain; the two never coincide because ready is low while full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cfg   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_cfg   <= i_cfg;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_cfg   = r_cfg;

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
module uart_tx_cfg
    import uart_tx_cfg_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         baud_tick,
    uart_tx_cfg_if.slave bus,
    output logic         tx_busy,
    output logic         tx_done,
    output logic         tx_out
);

    localparam int unsigned TickW = $clog2(2 * SB_TICK);
    localparam logic [TickW-1:0] TickBitLast   = TickW'(SB_TICK - 1);
    localparam logic [TickW-1:0] TickStop2Last = TickW'(2 * SB_TICK - 1);

    tx_state_e       r_state, w_state_d;
    logic [TickW-1:0] r_tick, w_tick_d;
    logic [2:0]      r_bit, w_bit_d;
    logic [DBIT-1:0] r_shift, w_shift_d;
    tx_cfg_t         r_cfg, w_cfg_d;
    logic            r_par, w_par_d;
    logic            r_tx_out, w_tx_out_d;

    logic            w_hold_valid;
    logic [DBIT-1:0] w_hold_data;
    tx_cfg_t         w_hold_cfg;
    tx_cfg_t         w_in_cfg;
    logic            w_accept;
    logic            w_stop_last;
    logic            w_direct;
    logic            w_load;
    logic [DBIT-1:0] w_load_data;
    tx_cfg_t         w_load_cfg;
    logic [3:0]      w_nbits_m1;

    assign w_in_cfg = '{dbits: bus.cfg_dbits, par: bus.cfg_par, stop2: bus.cfg_stop2};

    assign bus.tx_ready = ~w_hold_valid;
    assign w_accept     = bus.tx_valid & ~w_hold_valid;

    assign w_stop_last = (r_state == StStop) && baud_tick &&
                         (r_tick == (r_cfg.stop2 ? TickStop2Last : TickBitLast));

    // A word bypasses the hold when the shifter is free this very edge
    assign w_direct = w_accept & ((r_state == StIdle) | w_stop_last);
    assign w_load   = ((r_state == StIdle) & w_accept) | (w_stop_last & (w_hold_valid | w_accept));

    assign w_load_data = w_hold_valid ? w_hold_data : bus.tx_data;
    assign w_load_cfg  = w_hold_valid ? w_hold_cfg : w_in_cfg;
    assign w_nbits_m1  = dbits_decode(r_cfg.dbits) - 4'd1;

    uart_tx_cfg_hold #(
        .DBIT(DBIT)
    ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept & ~w_direct),
        .i_data (bus.tx_data),
        .i_cfg  (w_in_cfg),
        .i_drain(w_stop_last & w_hold_valid),
        .o_valid(w_hold_valid),
        .o_data (w_hold_data),
        .o_cfg  (w_hold_cfg)
    );

    // State, counters, shifter and the registered serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_tick   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_cfg    <= '0;
            r_par    <= 1'b0;
            r_tx_out <= 1'b1;
        end else begin
            r_state  <= w_state_d;
            r_tick   <= w_tick_d;
            r_bit    <= w_bit_d;
            r_shift  <= w_shift_d;
            r_cfg    <= w_cfg_d;
            r_par    <= w_par_d;
            r_tx_out <= w_tx_out_d;
        end
    end

    // Next-state: advance one serial bit every SB_TICK ticks, then reload from hold or input
    always_comb begin
        w_state_d  = r_state;
        w_tick_d   = r_tick;
        w_bit_d    = r_bit;
        w_shift_d  = r_shift;
        w_cfg_d    = r_cfg;
        w_par_d    = r_par;
        w_tx_out_d = 1'b1;
        tx_done    = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_tick_d = '0;
            end
            StStart: begin
                if (baud_tick) begin
                    if (r_tick == TickBitLast) begin
                        w_state_d = StData;
                        w_tick_d  = '0;
                    end else begin
                        w_tick_d = r_tick + 1'b1;
                    end
                end
            end
            StData: begin
                if (baud_tick) begin
                    if (r_tick == TickBitLast) begin
                        w_tick_d  = '0;
                        w_shift_d = r_shift >> 1;
                        if ({1'b0, r_bit} == w_nbits_m1) begin
                            w_bit_d   = '0;
                            w_state_d = parity_en(r_cfg.par) ? StParity : StStop;
                        end else begin
                            w_bit_d = r_bit + 1'b1;
                        end
                    end else begin
                        w_tick_d = r_tick + 1'b1;
                    end
                end
            end
            StParity: begin
                if (baud_tick) begin
                    if (r_tick == TickBitLast) begin
                        w_state_d = StStop;
                        w_tick_d  = '0;
                    end else begin
                        w_tick_d = r_tick + 1'b1;
                    end
                end
            end
            StStop: begin
                if (w_stop_last) begin
                    tx_done   = 1'b1;
                    w_state_d = StIdle;
                    w_tick_d  = '0;
                end else if (baud_tick) begin
                    w_tick_d = r_tick + 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_tick_d  = '0;
            end
        endcase

        // New frame: overrides the IDLE fall-through of the final stop tick (zero-gap restart)
        if (w_load) begin
            w_state_d = StStart;
            w_tick_d  = '0;
            w_bit_d   = '0;
            w_shift_d = w_load_data;
            w_cfg_d   = w_load_cfg;
            w_par_d   = parity_calc(MaxDbit'(w_load_data), w_load_cfg.dbits, w_load_cfg.par);
        end

        // Line level follows the state being entered so tx_out stays a plain register
        unique case (w_state_d)
            StStart:  w_tx_out_d = 1'b0;
            StData:   w_tx_out_d = w_shift_d[0];
            StParity: w_tx_out_d = w_par_d;
            default:  w_tx_out_d = 1'b1;
        endcase
    end

    assign tx_busy = (r_state != StIdle);
    assign tx_out  = r_tx_out;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed frame table, hand-written corner sequences and
// random traffic checked every cycle against a per-tick line model.
module tb_uart_tx_cfg;

    localparam int unsigned DBIT = 8;
    localparam int unsigned SB   = 16;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic baud_tick = 1'b0;
    logic tx_busy, tx_done, tx_out;
    bit   tick_all  = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_cfg_if #(.DBIT(DBIT)) bus ();

    uart_tx_cfg #(
        .DBIT   (DBIT),
        .SB_TICK(SB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_tick(baud_tick),
        .bus      (bus),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_out   (tx_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one entry per expected baud tick ----------------
    typedef struct packed {
        logic lvl;
        logic last;
    } ent_t;

    ent_t exp_q[$];
    int   exp_frames = 0;

    function automatic void push_frame(logic [7:0] d, logic [1:0] db, logic [1:0] par, logic st2);
        int   n;
        logic bits[$];
        logic p;
        ent_t e;
        n = int'(db) + 5;
        p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par == 2'b01) bits.push_back(p);
        else if (par == 2'b10) bits.push_back(~p);
        bits.push_back(1'b1);
        if (st2) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int t = 0; t < int'(SB); t++) begin
                e.lvl  = bits[b];
                e.last = (b == bits.size() - 1) && (t == int'(SB) - 1);
                exp_q.push_back(e);
            end
        end
        exp_frames++;
    endfunction

    // Compare every cycle, then advance the model across the coming rising edge
    initial begin
        logic exp_out, exp_done, acc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_frames = 0;
                chk("rst_tx_out", tx_out, 1);
                chk("rst_tx_busy", tx_busy, 0);
                chk("rst_tx_ready", bus.tx_ready, 1);
                chk("rst_tx_done", tx_done, 0);
            end else begin
                exp_out  = (exp_q.size() == 0) ? 1'b1 : exp_q[0].lvl;
                exp_done = baud_tick && (exp_q.size() > 0) && exp_q[0].last;
                chk("mon_tx_out", tx_out, exp_out);
                chk("mon_tx_busy", tx_busy, exp_q.size() > 0);
                chk("mon_tx_ready", bus.tx_ready, exp_frames < 2);
                chk("mon_tx_done", tx_done, exp_done);
                acc = bus.tx_valid && (exp_frames < 2);
                if (baud_tick && exp_q.size() > 0) begin
                    if (exp_q[0].last) exp_frames--;
                    void'(exp_q.pop_front());
                end
                if (acc) push_frame(bus.tx_data, bus.cfg_dbits, bus.cfg_par, bus.cfg_stop2);
            end
        end
    end

    // Baud strobe: every cycle for directed tests, random otherwise
    initial begin
        forever begin
            @(posedge clk);
            #1;
            baud_tick = tick_all ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic offer(input logic [7:0] d, input logic [1:0] db, input logic [1:0] par,
                         input logic st2);
        int budget;
        @(posedge clk);
        #1;
        bus.tx_data   = d;
        bus.cfg_dbits = db;
        bus.cfg_par   = par;
        bus.cfg_stop2 = st2;
        bus.tx_valid  = 1'b1;
        budget = 0;
        @(negedge clk);
        while (!bus.tx_ready && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        chk("handshake_wait", bus.tx_ready, 1);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        @(negedge clk);
        while (tx_busy && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        chk("idle_wait", tx_busy, 0);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  dbits;
        logic [1:0]  par;
        logic        stop2;
        logic [11:0] frame;   // line level per bit period, bit 0 = start bit
        int          nbits;   // bit periods incl. start, parity and stop bits
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        logic [11:0] cap;
        int          done_k;
        wait_idle();
        offer(v.data, v.dbits, v.par, v.stop2);
        cap    = '0;
        done_k = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ((k % int'(SB)) == int'(SB) / 2 && (k / int'(SB)) < 12) cap[k / int'(SB)] = tx_out;
            if (tx_done) begin
                done_k = k;
                break;
            end
        end
        @(negedge clk);
        chk($sformatf("vec%0d_frame", idx), 32'(cap), 32'(v.frame));
        chk($sformatf("vec%0d_ticks", idx), 32'(done_k + 1), 32'(v.nbits * int'(SB)));
        chk($sformatf("vec%0d_busy_after", idx), tx_busy, 0);
    endtask

    vec_t vecs[7];

    initial begin
        logic [11:0] cap1, cap2;
        int          done1, done2, idle_cycles;
        logic        ready_mid, ready_after, out_after;
        logic [7:0]  rd;
        logic [1:0]  rdb, rpar;
        logic        rst2;

        vecs[0] = '{data: 8'h55, dbits: 2'b11, par: 2'b00, stop2: 1'b0, frame: 12'h2AA, nbits: 10};
        vecs[1] = '{data: 8'h41, dbits: 2'b10, par: 2'b01, stop2: 1'b0, frame: 12'h282, nbits: 10};
        vecs[2] = '{data: 8'hFF, dbits: 2'b11, par: 2'b10, stop2: 1'b1, frame: 12'hFFE, nbits: 12};
        vecs[3] = '{data: 8'hE3, dbits: 2'b00, par: 2'b00, stop2: 1'b0, frame: 12'h046, nbits: 7};
        vecs[4] = '{data: 8'h2D, dbits: 2'b01, par: 2'b01, stop2: 1'b1, frame: 12'h35A, nbits: 10};
        vecs[5] = '{data: 8'h00, dbits: 2'b11, par: 2'b00, stop2: 1'b0, frame: 12'h200, nbits: 10};
        vecs[6] = '{data: 8'h7F, dbits: 2'b10, par: 2'b11, stop2: 1'b0, frame: 12'h1FE, nbits: 9};

        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus.cfg_dbits = 2'b11;
        bus.cfg_par   = 2'b00;
        bus.cfg_stop2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Back-to-back: second word offered during DATA of the first, must follow with no gap
        wait_idle();
        offer(8'hA5, 2'b11, 2'b00, 1'b0);
        cap1 = '0; cap2 = '0; done1 = -1; done2 = -1; idle_cycles = 0;
        ready_mid = 1'b1; ready_after = 1'b0; out_after = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k < 320 && !tx_busy) idle_cycles++;
            if (k % 16 == 8 && k < 160) cap1[k / 16] = tx_out;
            if (k % 16 == 8 && k >= 160 && k < 320) cap2[(k - 160) / 16] = tx_out;
            if (k == 100) ready_mid = bus.tx_ready;
            if (k == 160) begin
                ready_after = bus.tx_ready;
                out_after   = tx_out;
            end
            if (tx_done && done1 < 0) done1 = k;
            else if (tx_done && done2 < 0) done2 = k;
            if (bus.tx_valid && bus.tx_ready) begin
                @(posedge clk);
                #1;
                bus.tx_valid = 1'b0;
            end else if (k == 40) begin
                @(posedge clk);
                #1;
                bus.tx_data  = 8'h3C;
                bus.tx_valid = 1'b1;
            end
            if (done2 >= 0) break;
        end
        chk("b2b_frame1", 32'(cap1), 32'h34A);
        chk("b2b_frame2", 32'(cap2), 32'h278);
        chk("b2b_done1", 32'(done1), 32'd159);
        chk("b2b_done2", 32'(done2), 32'd319);
        chk("b2b_idle_cycles", 32'(idle_cycles), 32'd0);
        chk("b2b_ready_while_held", ready_mid, 0);
        chk("b2b_ready_after_drain", ready_after, 1);
        chk("b2b_start_no_gap", out_after, 0);

        // Reset mid-DATA with the hold full: line high, idle, ready, held word discarded
        wait_idle();
        offer(8'hAA, 2'b11, 2'b00, 1'b0);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 20) begin
                @(posedge clk);
                #1;
                bus.tx_data  = 8'h55;
                bus.tx_valid = 1'b1;
            end else if (k == 22) begin
                @(posedge clk);
                #1;
                bus.tx_valid = 1'b0;
            end
        end
        chk("pre_rst_hold_full", bus.tx_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx_out", tx_out, 1);
        chk("rst_mid_busy", tx_busy, 0);
        chk("rst_mid_ready", bus.tx_ready, 1);
        chk("rst_mid_done", tx_done, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", tx_busy, 0);
        chk("post_rst_tx_out", tx_out, 1);
        run_vec(vecs[5], 7);

        // Random traffic with sparse baud ticks and random offer gaps
        tick_all = 1'b0;
        for (int f = 0; f < 25; f++) begin
            rd   = 8'($urandom);
            rdb  = 2'($urandom);
            rpar = 2'($urandom);
            rst2 = 1'($urandom);
            repeat ($urandom_range(0, 30)) @(posedge clk);
            offer(rd, rdb, rpar, rst2);
        end
        wait_idle();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
